// File: rtl/axi_dma_copy_master.sv
// Single-channel DMA copy engine: one-beat AXI read then one-beat write per word.
// Optional watchdog: define AXI_DMA_TIMEOUT_EN to build the stall timeout and err flag.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   start, src_addr, dst_addr, len       transfer request, sampled in IDLE
//   busy, done, words_done, err          status
//   araddr/arvalid/arready               AR channel
//   rdata/rvalid/rready                  R channel
//   awaddr/awvalid/awready               AW channel
//   wdata/wstrb/wvalid/wready            W channel
//   bvalid/bready                        B channel
module axi_dma_copy_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_WIDTH-1:0]    words_done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    wdone_q;
  logic [LEN_WIDTH-1:0]    wdone_d;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    busy_q;
  logic                    done_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic r_take, b_take, last;

  assign ar_hs = arvalid_q & arready;
  assign r_hs  = rvalid & rready_q;
  assign aw_hs = awvalid_q & awready;
  assign w_hs  = wvalid_q & wready;
  assign b_hs  = bvalid & bready_q;

  // R only counts once AR is accepted (now or earlier).
  assign r_take = r_hs & (ar_hs | ~arvalid_q);

  // B only counts once both AW and W are accepted (now or earlier).
  assign b_take = b_hs
                & (~awvalid_q | awready)
                & (~wvalid_q | wready);

  assign wdone_d = wdone_q + LEN_WIDTH'(1);
  assign last    = (wdone_d == len_q);

`ifdef AXI_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          act, chg, any_hs, stall, tmo_fire;

  assign act    = (state_q == S_RD) | (state_q == S_WR);
  assign chg    = ((state_q == S_RD) & r_take)
                | ((state_q == S_WR) & b_take);
  assign any_hs = ar_hs | r_hs | aw_hs | w_hs | b_hs;
  assign stall  = act & ~chg & ~any_hs;
  assign tmo_fire = stall
                  & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      len_q     <= '0;
      wdone_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef AXI_DMA_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            araddr_q <= src_addr;
            awaddr_q <= dst_addr;
            len_q    <= len;
            wdone_q  <= '0;
            busy_q   <= 1'b1;
`ifdef AXI_DMA_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (ar_hs) arvalid_q <= 1'b0;
          if (r_take) begin
            wdata_q   <= rdata;
            rready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (b_take) begin
            wdone_q   <= wdone_d;
            araddr_q  <= araddr_q + STEP;
            awaddr_q  <= awaddr_q + STEP;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            if (last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
`ifdef AXI_DMA_TIMEOUT_EN
      tmo_q <= stall ? tmo_q + TW'(1) : '0;
      // Watchdog overrides whatever the FSM chose this cycle.
      if (tmo_fire) begin
        state_q   <= S_DONE;
        done_q    <= 1'b1;
        err_q     <= 1'b1;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        tmo_q     <= '0;
      end
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = wdone_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = '1;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_axi_dma_copy_master.sv
// Bench for axi_dma_copy_master: behavioural AXI slave with memory,
// word-copy reference model, directed and randomized transfers.
module tb_axi_dma_copy_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic busy, done, err;
  logic [LW-1:0] words_done;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready;
  logic bvalid, bready, arvalid, arready;
  logic rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  always #5 clk = ~clk;

  axi_dma_copy_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .words_done(words_done),
    .err(err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  // slave configuration (driven by the stimulus block only)
  bit zl = 1'b1;
  int ar_w = 0, r_w = 1, aw_w = 0, w_w = 0, b_w = 1;
  int b_limit = 32'h4000_0000;
  bit ld_en = 1'b0;
  logic [31:0] img [256];
  logic [31:0] model [256];

  // slave state (driven by the slave block only)
  logic [31:0] mem [256];
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] r_a = '0, aw_a = '0, w_d = '0;
  int b_hs_n = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    arready = arvalid && (ar_cnt >= ar_w);
    awready = awvalid && (aw_cnt >= aw_w);
    wready  = wvalid && (w_cnt >= w_w);
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    rdata   = mem[r_a[9:2]];
    if (zl) begin
      rvalid = arvalid;
      rdata  = mem[araddr[9:2]];
      bvalid = wvalid && (b_hs_n < b_limit);
    end else begin
      rvalid = r_pend && (r_cnt >= r_w - 1);
      bvalid = b_pend && (b_cnt >= b_w - 1);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      r_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; b_pend <= 0;
      aw_got <= 0; w_got <= 0;
    end else begin
      if (ld_en) mem <= img;
      if (arvalid && arready) ar_cnt <= 0;
      else if (arvalid) ar_cnt <= ar_cnt + 1;
      else ar_cnt <= 0;
      if (!zl && arvalid && arready) begin
        r_pend <= 1; r_a <= araddr; r_cnt <= 0;
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 0;
        else r_cnt <= r_cnt + 1;
      end
      if (awvalid && awready) aw_cnt <= 0;
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (wvalid && wready) w_cnt <= 0;
      else if (wvalid) w_cnt <= w_cnt + 1;
      else w_cnt <= 0;
      if (bvalid && bready) begin
        b_hs_n <= b_hs_n + 1;
        b_pend <= 0;
      end else if (b_pend) b_cnt <= b_cnt + 1;
      if ((aw_got || (awvalid && awready)) &&
          (w_got || (wvalid && wready))) begin
        mem[(aw_got ? aw_a[9:2] : awaddr[9:2])] <=
          (w_got ? w_d : wdata);
        aw_got <= 0; w_got <= 0;
        if (!zl && b_hs_n < b_limit) begin
          b_pend <= 1; b_cnt <= 0;
        end
      end else begin
        if (awvalid && awready) begin
          aw_got <= 1; aw_a <= awaddr;
        end
        if (wvalid && wready) begin
          w_got <= 1; w_d <= wdata;
        end
      end
    end
  end

  // protocol monitor: valids held until ready, payload stable
  int stab_bad = 0, ar_seen = 0, aw_seen = 0, done_n = 0;
  bit pa = 0, pw = 0, pd = 0;
  logic [31:0] pa_v = '0, pw_v = '0, pd_v = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      pa <= 0; pw <= 0; pd <= 0;
    end else begin
      stab_bad <= stab_bad
        + int'(pa && !(arvalid && araddr == pa_v))
        + int'(pw && !(awvalid && awaddr == pw_v))
        + int'(pd && !(wvalid && wdata == pd_v));
      pa <= arvalid && !arready; pa_v <= araddr;
      pw <= awvalid && !awready; pw_v <= awaddr;
      pd <= wvalid && !wready;   pd_v <= wdata;
      if (arvalid) ar_seen <= ar_seen + 1;
      if (awvalid) aw_seen <= aw_seen + 1;
      if (done) done_n <= done_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) img[i] = $urandom;
  endtask

  task automatic load();
    model = img;
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic copy_model(input logic [31:0] s,
                            input logic [31:0] d,
                            input int n);
    for (int i = 0; i < n; i++)
      model[(int'(d[9:2]) + i) % 256] =
        model[(int'(s[9:2]) + i) % 256];
  endtask

  function automatic int mism();
    int m = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== model[i]) m++;
    return m;
  endfunction

  task automatic set_zl();
    zl = 1; ar_w = 0; r_w = 1; aw_w = 0; w_w = 0; b_w = 1;
  endtask

  // inter >= 0: pulse a conflicting start that many cycles in
  task automatic run(input logic [31:0] s,
                     input logic [31:0] d,
                     input int n, input int inter,
                     output int lat, output bit ok);
    int st;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = LW'(n);
    start = 1'b1; st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 0; lat = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == inter) begin
        start = 1'b1; src_addr = ~s; dst_addr = s;
        len = LW'(7);
      end else if (i == inter + 1) start = 1'b0;
      if (done) begin
        lat = cyc - st; ok = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, n, b0, a0, w0, d0;
    bit ok, found;
    logic [31:0] s, d, wa;

    #2;
    chk("rst_ctl",
        {busy, done, err, arvalid, rready, awvalid,
         wvalid, bready}, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wdone", words_done, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("wstrb", wstrb, 4'hf);

    // zero-latency copy of 4 words
    fill(); load();
    copy_model(32'h40, 32'h100, 4);
    wa = model[19];
    b0 = b_hs_n;
    run(32'h40, 32'h100, 4, -1, lat, ok);
    chk("zl_done", ok, 1);
    chk("zl_lat", lat, 9);
    chk("zl_busy_done", busy, 1);
    chk("zl_wdone", words_done, 4);
    @(negedge clk);
    chk("zl_busy_idle", busy, 0);
    chk("zl_mem", mism(), 0);
    chk("zl_last_word", mem[8'h43], wa);
    chk("zl_bcnt", b_hs_n - b0, 4);
    chk("err_clear", err, 0);

    // zero-length transfer
    a0 = ar_seen; w0 = aw_seen;
    run(32'h80, 32'h90, 0, -1, lat, ok);
    chk("z0_done", ok, 1);
    chk("z0_lat", lat, 1);
    chk("z0_wdone", words_done, 0);
    repeat (3) @(negedge clk);
    chk("z0_ar", ar_seen - a0, 0);
    chk("z0_aw", aw_seen - w0, 0);
    chk("z0_mem", mism(), 0);

    // backpressure
    zl = 0; ar_w = 3; r_w = 2;
    aw_w = $urandom_range(0, 2); w_w = aw_w + 1; b_w = 4;
    fill(); load();
    s = $urandom & 32'hFFFF_FFFC;
    d = s + 32'h200;
    copy_model(s, d, 2);
    b0 = b_hs_n;
    run(s, d, 2, -1, lat, ok);
    chk("bp_done", ok, 1);
    chk("bp_wdone", words_done, 2);
    @(negedge clk);
    chk("bp_mem", mism(), 0);
    chk("bp_bcnt", b_hs_n - b0, 2);
    chk("bp_stable", stab_bad, 0);

    // conflicting start mid-transfer is ignored
    fill(); load();
    s = $urandom & 32'hFFFF_FFFC;
    d = s + 32'h100;
    copy_model(s, d, 3);
    d0 = done_n;
    run(s, d, 3, 4, lat, ok);
    chk("ign_done", ok, 1);
    chk("ign_wdone", words_done, 3);
    a0 = ar_seen;
    repeat (10) @(negedge clk);
    chk("ign_mem", mism(), 0);
    chk("ign_one_done", done_n - d0, 1);
    chk("ign_busy", busy, 0);
    chk("ign_no_rerun", ar_seen - a0, 0);

    // address wrap
    set_zl();
    fill(); load();
    copy_model(32'hFFFF_FFF8, 32'h200, 4);
    run(32'hFFFF_FFF8, 32'h200, 4, -1, lat, ok);
    chk("wr_lat", lat, 9);
    chk("wr_araddr", araddr, 32'h8);
    chk("wr_awaddr", awaddr, 32'h210);
    @(negedge clk);
    chk("wr_mem", mism(), 0);

    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) set_zl();
      else begin
        zl = 0;
        ar_w = $urandom_range(0, 3);
        r_w = $urandom_range(1, 4);
        aw_w = $urandom_range(0, 3);
        w_w = $urandom_range(0, 3);
        b_w = $urandom_range(1, 4);
      end
      fill(); load();
      n = $urandom_range(1, 8);
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      copy_model(s, d, n);
      b0 = b_hs_n;
      run(s, d, n, -1, lat, ok);
      chk("rnd_done", ok, 1);
      chk("rnd_wdone", words_done, n);
      if (zl) chk("rnd_lat", lat, 2 * n + 1);
      @(negedge clk);
      chk("rnd_mem", mism(), 0);
      chk("rnd_bcnt", b_hs_n - b0, n);
    end
    chk("rnd_stable", stab_bad, 0);

    // reset while waiting for B
    zl = 0; ar_w = 0; r_w = 1; aw_w = 0; w_w = 0; b_w = 8;
    fill(); load();
    @(posedge clk); #1;
    src_addr = 32'h20; dst_addr = 32'h300;
    len = LW'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awvalid) begin
        found = 1;
        break;
      end
    end
    chk("rs_in_wr", found, 1);
    d0 = done_n;
    #2 reset_n = 1'b0;
    #1;
    chk("rs_ctl",
        {busy, done, err, arvalid, rready, awvalid,
         wvalid, bready}, 0);
    chk("rs_addr", {araddr, awaddr}, 0);
    chk("rs_wdata", wdata, 0);
    chk("rs_wdone", words_done, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rs_no_done", done_n - d0, 0);
    set_zl();
    fill(); load();
    copy_model(32'h44, 32'h88, 2);
    run(32'h44, 32'h88, 2, -1, lat, ok);
    chk("rs_lat", lat, 5);
    chk("rs_wdone2", words_done, 2);
    @(negedge clk);
    chk("rs_mem", mism(), 0);

`ifdef AXI_DMA_TIMEOUT_EN
    // second B never comes
    set_zl();
    fill(); load();
    b_limit = b_hs_n + 1;
    run(32'h10, 32'h400, 3, -1, lat, ok);
    chk("to_done", ok, 1);
    chk("to_lat", lat, 21);
    chk("to_err", err, 1);
    chk("to_wdone", words_done, 1);
    b_limit = 32'h4000_0000;
    @(negedge clk);
    chk("to_err_hold", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    chk("stable_all", stab_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_dma_copy_master.md
Name: axi_dma_copy_master

Overview:
Single-channel DMA copy engine and AXI initiator for the subsystem memory port. It copies a block of words from a source address to a destination address, one word at a time. Each word is one single-beat read (AR/R) followed by one single-beat write (AW/W/B). The engine is compatible with the zero-latency memory, whose rvalid follows arvalid and whose bvalid follows wvalid, and it also works with slaves that apply backpressure.

Parameters:
ADDR_WIDTH, 32, byte address width of both channels
DATA_WIDTH, 32, data width; one word = DATA_WIDTH/8 bytes
LEN_WIDTH, 16, width of the transfer length in words
TIMEOUT_CYCLES, 256, watchdog limit; used only with AXI_DMA_TIMEOUT_EN

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a transfer; sampled in IDLE only
src_addr  in  ADDR_WIDTH  source byte address; sampled on accepted start
dst_addr  in  ADDR_WIDTH  destination byte address; sampled on accepted start
len  in  LEN_WIDTH  number of words; sampled on accepted start
busy  out  1  high from the cycle after start through DONE
done  out  1  one-cycle completion pulse
words_done  out  LEN_WIDTH  words fully written (B handshake seen) in the current or last transfer
err  out  1  timeout flag; constant 0 without AXI_DMA_TIMEOUT_EN
awaddr  out  ADDR_WIDTH  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  DATA_WIDTH  write data (captured read word)
wstrb  out  DATA_WIDTH/8  write strobe; always all ones
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready
araddr  out  ADDR_WIDTH  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_WIDTH  read data
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All valid/ready outputs, busy, done and err are 0. awaddr, araddr, wdata and words_done are 0. Reset mid-transfer aborts immediately with no done pulse.
- States:
  - IDLE: start accepted -> latch addresses and len, clear words_done and err. If len==0, go to DONE; otherwise go to RD.
  - RD: arvalid=1 until the AR handshake; rready=1 throughout. R handshake (rvalid&&rready) captures rdata into wdata.
    - R handshake in the same cycle as AR, or after it, -> WR.
    - AR done but no R yet -> stay in RD with arvalid=0 and rready=1.
  - WR: awvalid and wvalid assert together. Each drops independently after its own handshake. bready=1 throughout.
    - B handshake counts only when it falls in the cycle of the last AW/W handshake or later.
    - On B handshake: words_done++, both addresses += DATA_WIDTH/8.
    - If words_done reaches len, go to DONE; otherwise go back to RD.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Valid/address/data stability: araddr, awaddr and wdata are held stable while the corresponding valid is high. A valid, once raised, is never dropped before its ready.
- Throughput: against an always-ready zero-latency slave, 2 cycles per word. For len=N, done asserts 2N+1 cycles after the start cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is raised on wrap.
- start while busy: ignored, no effect on the latched parameters.
- len is an unsigned word count; the maximum is 2^LEN_WIDTH-1.

Optional Feature:
AXI_DMA_TIMEOUT_EN
- Defined:
  - A counter clears on every state change and on every handshake, and increments in RD and WR otherwise.
  - When it reaches TIMEOUT_CYCLES: drop all valids and readies, set err=1, go to DONE, pulse done. words_done reports the words completed so far.
  - err holds until the next accepted start or reset.
- Undefined: no counter is built, err is tied 0, and the engine waits indefinitely.

Test Plan:
- Zero-latency memory, mem[0x10..0x13]={A,B,C,D}, src=0x40, dst=0x100, len=4, start -> mem[0x40..0x43]={A,B,C,D}; done asserts 9 cycles after start; words_done=4.
- len=0, start -> done asserts 1 cycle after start; no arvalid or awvalid ever asserted; words_done=0.
- Backpressure: arready low 3 cycles, R 2 cycles after AR, wready 1 cycle later than awready, bvalid 4 cycles late; len=2 -> correct copy; valids and addresses held stable throughout; exactly 2 B handshakes.
- start pulsed again mid-transfer with different src/dst/len -> ignored; the original transfer completes unchanged.
- reset_n asserted while in WR -> all outputs go to 0 asynchronously; no done pulse. A new start after release runs normally.
- With AXI_DMA_TIMEOUT_EN and TIMEOUT_CYCLES=16, bvalid never asserted -> after 16 stalled cycles err=1 and done pulses; words_done equals the words completed before the stall.
